// File: rtl/evm_pkg.sv
// Shared EVM definitions: count width, party indices and the result-reader FSM encoding.
package evm_pkg;
  localparam int COUNT_W = 4;
  localparam int TOTAL_W = COUNT_W + 2;

  localparam logic [1:0] PARTY_A = 2'd0;
  localparam logic [1:0] PARTY_B = 2'd1;
  localparam logic [1:0] PARTY_C = 2'd2;
  localparam logic [1:0] PARTY_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    PRESENT = 2'b10
  } state_e;
endpackage

// File: rtl/evm_result_reader_if.sv
// Signal bundle between the result reader (master) and Top / display logic (slave).
interface evm_result_reader_if;
  import evm_pkg::*;

  // Handshake: a record transfers on any rising edge where result_valid && result_ready.
  // result_valid never drops and the record never changes until that edge; result_ready
  // may be high at any time and is ignored outside PRESENT.
  logic               start;
  logic [1:0]         sel;
  logic [COUNT_W-1:0] count_in;
  logic               vote_lock;
  logic               busy;
  logic               result_valid;
  logic               result_ready;
  logic [1:0]         winner;
  logic [COUNT_W-1:0] winner_count;
  logic [TOTAL_W-1:0] total;
  logic               tie;
  logic               no_votes;
  logic               done;
  state_e             state;

  modport master (
    input  start, count_in, result_ready,
    output sel, vote_lock, busy, result_valid, winner, winner_count,
           total, tie, no_votes, done, state
  );

  modport slave (
    output start, count_in, result_ready,
    input  sel, vote_lock, busy, result_valid, winner, winner_count,
           total, tie, no_votes, done, state
  );
endinterface

// File: rtl/evm_max_tracker.sv
// Running max / winner / tie / total over the four party counts, captured one party at a time.
module evm_max_tracker
  import evm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               capture_i,
  input  logic               last_i,
  input  logic [1:0]         idx_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic [COUNT_W-1:0] max_o,
  output logic [1:0]         winner_o,
  output logic [TOTAL_W-1:0] total_o,
  output logic               tie_o,
  output logic               no_votes_o
);
  logic [COUNT_W-1:0] max_q, max_d;
  logic [1:0]         win_q, win_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               tie_q, tie_d;
  logic               nov_q, nov_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      win_q   <= '0;
      total_q <= '0;
      tie_q   <= 1'b0;
      nov_q   <= 1'b0;
    end else begin
      max_q   <= max_d;
      win_q   <= win_d;
      total_q <= total_d;
      tie_q   <= tie_d;
      nov_q   <= nov_d;
    end
  end

  always_comb begin
    max_d   = max_q;
    win_d   = win_q;
    total_d = total_q;
    tie_d   = tie_q;
    nov_d   = nov_q;
    if (clear_i) begin
      max_d   = '0;
      win_d   = '0;
      total_d = '0;
      tie_d   = 1'b0;
      nov_d   = 1'b0;
    end else if (capture_i) begin
      total_d = total_q + TOTAL_W'(count_i);
      // Strict '>' keeps the lowest index on ties.
      if (idx_i == PARTY_A) begin
        max_d = count_i;
        win_d = PARTY_A;
        tie_d = 1'b0;
      end else if (count_i > max_q) begin
        max_d = count_i;
        win_d = idx_i;
        tie_d = 1'b0;
      end else if (count_i == max_q) begin
        tie_d = 1'b1;
      end
      if (last_i) nov_d = (total_d == '0);
    end
  end

  // An all-zero ballot looks like a four-way tie at 0; that is reported as no votes instead.
  assign max_o      = max_q;
  assign winner_o   = nov_q ? PARTY_A : win_q;
  assign total_o    = total_q;
  assign tie_o      = tie_q & ~nov_q;
  assign no_votes_o = nov_q;
endmodule

// File: rtl/evm_result_reader.sv
// Scans the four party counts out of Top via sel/count_in and hands one result record downstream.
module evm_result_reader
  import evm_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input logic                 clk,
  input logic                 reset,
  evm_result_reader_if.master rd
);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] settle_q, settle_d;
  logic       done_q, done_d;
  logic       clear, capture;

  logic [COUNT_W-1:0] trk_max;
  logic [1:0]         trk_winner;
  logic [TOTAL_W-1:0] trk_total;
  logic               trk_tie;
  logic               trk_nov;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd.start) begin
          state_d  = READ;
          idx_d    = PARTY_A;
          sel_d    = PARTY_A;
          settle_d = SETTLE_LD;
          clear    = 1'b1;
        end
      end
      READ: begin
        // Give Top's mux SETTLE cycles after each sel change before trusting count_in.
        if (settle_q != '0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          capture = 1'b1;
          if (idx_q == PARTY_D) begin
            state_d = PRESENT;
          end else begin
            idx_d    = idx_q + 2'd1;
            sel_d    = idx_q + 2'd1;
            settle_d = SETTLE_LD;
          end
        end
      end
      PRESENT: begin
        if (rd.result_ready) begin
          state_d = IDLE;
          idx_d   = PARTY_A;
          sel_d   = PARTY_A;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  evm_max_tracker u_tracker (
    .clk        (clk),
    .rst        (reset),
    .clear_i    (clear),
    .capture_i  (capture),
    .last_i     (idx_q == PARTY_D),
    .idx_i      (idx_q),
    .count_i    (rd.count_in),
    .max_o      (trk_max),
    .winner_o   (trk_winner),
    .total_o    (trk_total),
    .tie_o      (trk_tie),
    .no_votes_o (trk_nov)
  );

  assign rd.sel          = sel_q;
  assign rd.busy         = (state_q != IDLE);
  assign rd.vote_lock    = (state_q != IDLE);
  assign rd.result_valid = (state_q == PRESENT);
  assign rd.done         = done_q;
  assign rd.state        = state_q;
  assign rd.winner       = trk_winner;
  assign rd.winner_count = trk_max;
  assign rd.total        = trk_total;
  assign rd.tie          = trk_tie;
  assign rd.no_votes     = trk_nov;
endmodule

// File: tb/tb_evm_result_reader.sv
// Bench for evm_result_reader: one instance with SETTLE=1, one with SETTLE=0, shared count source.
module tb_evm_result_reader;
  import evm_pkg::*;

  logic       clk;
  logic       reset;
  logic       start_s;
  logic       ready_s;
  logic       use0;
  logic [3:0] counts[4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] exp_q[$];

  evm_result_reader_if bus1 ();
  evm_result_reader_if bus0 ();

  assign bus1.start        = start_s & ~use0;
  assign bus0.start        = start_s & use0;
  assign bus1.result_ready = ready_s;
  assign bus0.result_ready = ready_s;
  assign bus1.count_in     = counts[bus1.sel];
  assign bus0.count_in     = counts[bus0.sel];

  evm_result_reader #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .rd(bus1));
  evm_result_reader #(.SETTLE(0)) dut0 (.clk(clk), .reset(reset), .rd(bus0));

  // Observed view: {done, valid, busy, vote_lock, sel[1:0], record[13:0]}
  logic [19:0] v1, v0, o;
  assign v1 = {bus1.done, bus1.result_valid, bus1.busy, bus1.vote_lock, bus1.sel,
               bus1.winner, bus1.winner_count, bus1.total, bus1.tie, bus1.no_votes};
  assign v0 = {bus0.done, bus0.result_valid, bus0.busy, bus0.vote_lock, bus0.sel,
               bus0.winner, bus0.winner_count, bus0.total, bus0.tie, bus0.no_votes};
  assign o  = use0 ? v0 : v1;

  logic [13:0] o_rec;
  logic [1:0]  o_sel;
  logic        o_valid, o_done;
  assign o_rec   = o[13:0];
  assign o_sel   = o[15:14];
  assign o_valid = o[18];
  assign o_done  = o[19];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record: {winner[1:0], winner_count[3:0], total[5:0], tie, no_votes}
  function automatic logic [13:0] model(input logic [3:0] a, b, c, d);
    logic [3:0] v[4];
    logic [3:0] mx;
    logic [1:0] w;
    logic       t;
    logic [5:0] tot;
    v = '{a, b, c, d};
    mx = a; w = 2'd0; t = 1'b0; tot = 6'd0;
    for (int i = 0; i < 4; i++) begin
      tot = tot + {2'b00, v[i]};
      if (i > 0) begin
        if (v[i] > mx) begin mx = v[i]; w = 2'(i); t = 1'b0; end
        else if (v[i] == mx) t = 1'b1;
      end
    end
    if (tot == 6'd0) begin t = 1'b0; w = 2'd0; end
    return {w, mx, tot, t, (tot == 6'd0)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start_s = 1'b0; ready_s = 1'b0; use0 = 1'b0;
    counts = '{4'd0, 4'd0, 4'd0, 4'd0};
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      use0 = u[0];
      #1;
      n_cmp++;
      if (o !== 20'd0) begin
        n_bad++;
        $display("FAIL reset_outputs[dut%0d]: got %h want 00000", u == 1 ? 0 : 1, o);
      end
    end
    n_cmp++;
    if (bus1.state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d want %0d", bus1.state, IDLE);
    end
    use0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One complete read-out; restart_at pulses start again on that cycle of the scan.
  task automatic run_scan(input logic [3:0] a, b, c, d, input bit sel0,
                          input int hold_low, input int restart_at, input string tag);
    logic [13:0] exp;
    int s, k, extra;
    bit seen;
    s = sel0 ? 0 : 1;
    use0 = sel0;
    counts = '{a, b, c, d};
    exp_q.push_back(model(a, b, c, d));
    ready_s = (hold_low == 0);
    @(negedge clk);
    start_s = 1'b1;
    k = 0; seen = 1'b0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      start_s = (k == restart_at);
      if (o_valid) seen = 1'b1;
      else if (k <= 4 * (s + 1)) begin
        n_cmp++;
        if (o_sel !== 2'((k - 1) / (s + 1))) begin
          n_bad++;
          $display("FAIL %s sel_step[%0d]: got %0d want %0d", tag, k, o_sel, (k - 1) / (s + 1));
        end
      end
    end
    start_s = 1'b0;
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s valid_timeout: got no result_valid want one within 100 cycles", tag);
      return;
    end
    if (k - 1 != 4 * (s + 1)) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, k - 1, 4 * (s + 1));
    end
    n_cmp++;
    if (o_rec !== exp) begin
      n_bad++;
      $display("FAIL %s record: got %h want %h", tag, o_rec, exp);
    end
    for (int h = 1; h <= hold_low; h++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_valid, o_rec} !== {1'b1, exp}) begin
        n_bad++;
        $display("FAIL %s hold[%0d]: got v=%0b %h want v=1 %h", tag, h, o_valid, o_rec, exp);
      end
    end
    ready_s = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o[19:14] !== 6'b100000) begin
      n_bad++;
      $display("FAIL %s handshake {done,valid,busy,lock,sel}: got %b want 100000", tag, o[19:14]);
    end
    ready_s = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_done, o_rec} !== {1'b0, exp}) begin
      n_bad++;
      $display("FAIL %s idle_after: got done=%0b %h want done=0 %h", tag, o_done, o_rec, exp);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid || o_done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL %s extra_episode: got %0d active cycles want 0", tag, extra);
    end
  endtask

  task automatic test_basic();
    run_scan(4'd7, 4'd2, 4'd3, 4'd3, 1'b0, 0, 0, "basic");
  endtask

  task automatic test_tie();
    run_scan(4'd3, 4'd5, 4'd5, 4'd1, 1'b0, 0, 0, "tie");
  endtask

  task automatic test_no_votes();
    run_scan(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, "no_votes");
  endtask

  task automatic test_backpressure_max();
    run_scan(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 5, 0, "max_bp");
  endtask

  task automatic test_start_while_busy();
    run_scan(4'd2, 4'd6, 4'd1, 4'd9, 1'b0, 0, 3, "start_busy");
  endtask

  task automatic test_reset_mid_read();
    int k, act;
    use0 = 1'b0;
    counts = '{4'd4, 4'd8, 4'd6, 4'd2};
    ready_s = 1'b1;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    k = 0;
    while (o_sel !== 2'd2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (o_sel !== 2'd2) begin
      n_bad++;
      $display("FAIL mid_reset_reach_idx2: got sel=%0d want 2", o_sel);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (o !== 20'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h want 00000", o);
    end
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_done || o_valid || o[16]) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL mid_reset_quiet: got %0d active cycles want 0", act);
    end
    run_scan(4'd1, 4'd9, 4'd9, 4'd4, 1'b0, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      run_scan(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               r[0], int'($urandom_range(0, 3)), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_no_votes();
    test_backpressure_max();
    test_start_while_busy();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/evm_result_reader.md
Name: evm_result_reader

Overview:
Read-out controller on the result side of the EVM `Top` block. It drives `Top`'s 2-bit party select, samples the 4-bit `mux_out` count for each of the four parties (a, b, c, d) and accumulates the total. It determines the winner, tie and no-vote status, then presents one result record through a valid/ready handshake to the display/announcement logic. While busy it asserts `vote_lock`, which the control unit uses to gate `master_enable`, so no vote can land mid-scan.

Parameters:
- COUNT_W, 4, width of one party count; must match `Top` `mux_out`.
- SETTLE, 1, idle cycles after changing `sel` before `count_in` is sampled. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a read-out; sampled in IDLE only.
- sel  out  2  party select to `Top` `s` (0=a, 1=b, 2=c, 3=d).
- count_in  in  COUNT_W  count from `Top` `mux_out` for the party on `sel`.
- vote_lock  out  1  high while a read-out is in progress; control unit forces `master_enable`=0.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  result record valid.
- result_ready  in  1  consumer accepts the record.
- winner  out  2  index of the party with the highest count.
- winner_count  out  COUNT_W  highest count.
- total  out  COUNT_W+2  sum of all four counts.
- tie  out  1  two or more parties share the highest nonzero count.
- no_votes  out  1  total == 0.
- done  out  1  one-cycle pulse on handshake completion.

Behaviour:
- Reset, asynchronous, in any state: state=IDLE; every output and internal register = 0 (`sel`, `winner`, `winner_count`, `total`, `tie`, `no_votes`, `result_valid`, `done`, `busy`, `vote_lock`, party index, settle counter).
- FSM states: IDLE, READ, PRESENT.
- IDLE:
  - `start`=1 at a clock edge → READ, with idx=0, `sel`=0, settle counter=SETTLE, and running max/winner/total/tie cleared.
  - `busy` and `vote_lock` go high on the same edge.
- READ:
  - `sel` is registered and equals idx.
  - While the settle counter is nonzero, decrement it each cycle.
  - When it is 0, capture `count_in` on that edge and update:
    - total += count_in, zero-extended to COUNT_W+2 bits; no overflow is possible (max 4×15=60).
    - idx==0: max=count_in, winner=0, tie=0.
    - idx>0, count_in > max: max=count_in, winner=idx, tie=0.
    - idx>0, count_in == max: tie=1; winner is unchanged, so the lowest index wins ties.
    - count_in < max: no change.
  - After a capture with idx<3: idx++, `sel`=idx+1, settle counter reloads SETTLE.
  - After a capture with idx==3: → PRESENT.
- Latency: each party takes SETTLE+1 cycles. `result_valid` rises 4×(SETTLE+1) edges after the edge that sampled `start` (8 cycles at default).
- PRESENT:
  - `result_valid`=1. `winner`, `winner_count`, `total`, `tie` and `no_votes` are stable and held until the handshake.
  - `no_votes`=(total==0); when `no_votes`=1, `tie` is forced to 0 and `winner`=0.
  - `result_valid` & `result_ready` at an edge → IDLE. On that edge `result_valid`=0, `busy`=0, `vote_lock`=0, and `done`=1 for exactly one cycle.
  - The result outputs keep their last values in IDLE until the next `start`.
- `result_ready` high early, before PRESENT: ignored; the handshake completes on the first PRESENT cycle.
- `start` while busy: ignored, not queued.
- `start` held high continuously: a new read-out begins on the edge after `done`.
- `count_in` is trusted; no range check.
- `sel` stays at its last value in PRESENT and is returned to 0 on entering IDLE.
- Reset asserted mid-READ or mid-PRESENT aborts the scan; no `done`; `vote_lock` drops immediately.

Decomposition:
- Shared package `evm_pkg`:
  - COUNT_W.
  - Party index constants PARTY_A..PARTY_D = 0..3.
  - FSM state encoding: IDLE=2'b00, READ=2'b01, PRESENT=2'b10.
  - Also used by `Top` and the testbench.
- One natural sub-module, `evm_max_tracker`: holds the running max/winner/tie/total registers, with inputs clear, capture, idx and count. The FSM and settle counter stay in `evm_result_reader`.

Test Plan:
- Counts a=7, b=2, c=3, d=3, SETTLE=1, `start` pulse, `result_ready`=1 → `sel` steps 0,1,2,3 holding 2 cycles each; `result_valid` 8 cycles after start; winner=0, winner_count=7, total=15, tie=0, no_votes=0; `done` for 1 cycle.
- Counts a=3, b=5, c=5, d=1 → winner=1, winner_count=5, tie=1, total=14.
- All counts 0 → no_votes=1, tie=0, winner=0, total=0.
- Counts all 15, SETTLE=0, `result_ready` held low for 5 cycles after `result_valid` → outputs stable throughout; total=60, tie=1, winner=0; `done` on the cycle after `result_ready` rises.
- Reset pulse during READ at idx=2 → all outputs 0 immediately; `vote_lock`=0; no `done`; a later `start` gives a full correct scan.
- `start` pulsed again during READ → ignored; exactly one `result_valid` episode and one `done`.
